// File: rtl/mod_step_counter.sv
// Parametrised up/down step counter with runtime modulo limit, wrap/saturate
// mode, synchronous load, terminal-count flag and a registered wrap pulse.
module mod_step_counter #(
    parameter int WIDTH = 4,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    input  logic             down,
    input  logic             saturate,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;
    logic [WIDTH:0]   limit_x;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_nxt;
    logic             wrapped_nxt;

    // One guard bit so neither the add nor the subtract can alias modulo 2^WIDTH.
    assign limit_x      = {1'b0, limit};
    assign up_sum       = {1'b0, count} + STEP_X;
    assign dn_diff      = {1'b0, count} - STEP_X;
    assign load_clamped = (load_value > limit) ? limit : load_value;

    always_comb begin
        count_nxt   = count;
        wrapped_nxt = 1'b0;
        if (load) begin
            count_nxt = load_clamped;
        end else if (enable) begin
            if (!down) begin
                if (up_sum <= limit_x) begin
                    count_nxt = up_sum[WIDTH-1:0];
                end else if (saturate) begin
                    count_nxt = limit;
                end else begin
                    count_nxt   = '0;
                    wrapped_nxt = 1'b1;
                end
            end else begin
                // A count stranded above a lowered limit is clamped, not wrapped.
                if (count > limit) begin
                    count_nxt = limit;
                end else if (!dn_diff[WIDTH]) begin
                    count_nxt = dn_diff[WIDTH-1:0];
                end else if (saturate) begin
                    count_nxt = '0;
                end else begin
                    count_nxt   = limit;
                    wrapped_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            wrapped <= 1'b0;
        end else begin
            count   <= count_nxt;
            wrapped <= wrapped_nxt;
        end
    end

    assign tc = down ? (count == '0) : (count == limit);

endmodule

// File: tb/tb_mod_step_counter.sv
// Scoreboard bench for mod_step_counter: two instances (STEP=1, STEP=3) share
// stimulus; an arithmetic reference model predicts each cycle's outputs.
module tb_mod_step_counter;

    logic       clock = 1'b0;
    logic       reset, enable, load, down, saturate;
    logic [3:0] load_value, limit;
    logic [3:0] count1, count3;
    logic       tc1, tc3, wrapped1, wrapped3;

    always #5 clock = ~clock;

    mod_step_counter #(.WIDTH(4), .STEP(1)) u_dut1 (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .load_value(load_value), .limit(limit), .down(down), .saturate(saturate),
        .count(count1), .tc(tc1), .wrapped(wrapped1)
    );

    mod_step_counter #(.WIDTH(4), .STEP(3)) u_dut3 (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .load_value(load_value), .limit(limit), .down(down), .saturate(saturate),
        .count(count3), .tc(tc3), .wrapped(wrapped3)
    );

    typedef struct {
        int c1; bit w1; bit t1;
        int c3; bit w3; bit t3;
    } exp_t;

    exp_t q[$];
    int   m1, m3;
    bit   done = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference rule set written as plain integer arithmetic.
    function automatic int model(input int c, input int stp, input bit rst, input bit ld,
                                 input bit en, input bit dn, input bit sat,
                                 input int lv, input int lim, output bit w);
        w = 1'b0;
        if (rst) return 0;
        if (ld) return (lv < lim) ? lv : lim;
        if (!en) return c;
        if (!dn) begin
            if (c + stp <= lim) return c + stp;
            if (sat) return lim;
            w = 1'b1;
            return 0;
        end
        if (c > lim) return lim;
        if (c >= stp) return c - stp;
        if (sat) return 0;
        w = 1'b1;
        return lim;
    endfunction

    task automatic drive(input bit rst, input bit ld, input bit en, input bit dn,
                         input bit sat, input int lv, input int lim);
        exp_t e;
        @(negedge clock);
        reset = rst; load = ld; enable = en; down = dn; saturate = sat;
        load_value = 4'(lv); limit = 4'(lim);
        m1 = model(m1, 1, rst, ld, en, dn, sat, lv, lim, e.w1);
        m3 = model(m3, 3, rst, ld, en, dn, sat, lv, lim, e.w3);
        e.c1 = m1;
        e.c3 = m3;
        e.t1 = dn ? (m1 == 0) : (m1 == lim);
        e.t3 = dn ? (m3 == 0) : (m3 == lim);
        q.push_back(e);
    endtask

    task automatic run(input int n, input bit dn, input bit sat, input int lim);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, dn, sat, 0, lim);
    endtask

    // Monitor: every driven cycle yields one expectation, checked after the edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_tests += 6;
            if (int'(count1) != e.c1) begin
                n_fail++;
                $display("FAIL count_s1 t=%0t got %0d want %0d", $time, count1, e.c1);
            end
            if (wrapped1 != e.w1) begin
                n_fail++;
                $display("FAIL wrapped_s1 t=%0t got %0b want %0b", $time, wrapped1, e.w1);
            end
            if (tc1 != e.t1) begin
                n_fail++;
                $display("FAIL tc_s1 t=%0t got %0b want %0b", $time, tc1, e.t1);
            end
            if (int'(count3) != e.c3) begin
                n_fail++;
                $display("FAIL count_s3 t=%0t got %0d want %0d", $time, count3, e.c3);
            end
            if (wrapped3 != e.w3) begin
                n_fail++;
                $display("FAIL wrapped_s3 t=%0t got %0b want %0b", $time, wrapped3, e.w3);
            end
            if (tc3 != e.t3) begin
                n_fail++;
                $display("FAIL tc_s3 t=%0t got %0b want %0b", $time, tc3, e.t3);
            end
        end else if (done) begin
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; down = 1'b0; saturate = 1'b0;
        load_value = '0; limit = 4'd15;
        m1 = 0; m3 = 0;

        // Reset for two edges, then full-range up count with wrap.
        drive(1, 0, 0, 0, 0, 0, 15);
        drive(1, 0, 0, 0, 0, 0, 15);
        run(20, 0, 0, 15);

        // Modulo 9, then saturate at the limit.
        drive(1, 0, 0, 0, 0, 0, 9);
        run(22, 0, 0, 9);
        run(4, 0, 1, 9);

        // Down count from a loaded 7, wrap then saturate.
        drive(0, 1, 0, 1, 0, 7, 10);
        run(8, 1, 0, 10);
        drive(0, 1, 0, 1, 1, 7, 10);
        run(5, 1, 1, 10);

        // Load clamps and beats enable; next up step wraps from the limit.
        drive(0, 1, 1, 0, 0, 12, 5);
        drive(0, 0, 1, 0, 0, 0, 5);

        // Limit lowered below the count: up wraps, down clamps.
        drive(0, 1, 0, 0, 0, 8, 15);
        drive(0, 0, 1, 0, 0, 0, 3);
        drive(0, 1, 0, 1, 0, 8, 15);
        drive(0, 0, 1, 1, 0, 0, 3);

        // limit = 0 in every direction/mode.
        run(3, 0, 0, 0);
        run(3, 1, 0, 0);
        run(3, 0, 1, 0);
        run(3, 1, 1, 0);

        // Reset mid-count with enable high, then resume.
        drive(0, 1, 0, 0, 0, 6, 15);
        drive(1, 0, 1, 0, 0, 0, 15);
        run(4, 0, 0, 15);

        // Randomised mix with occasional loads, resets and limit changes.
        begin
            int lim = 12;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 9) == 0) lim = $urandom_range(0, 15);
                drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 15), lim);
            end
        end

        @(negedge clock);
        done = 1'b1;
    end

    // Absolute bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout reached before completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mod_step_counter.md
Name: mod_step_counter

Overview:
- Parametrised successor to the team's fixed 4-bit free-running incrementer.
- Generalised in width and step size.
- Adds a runtime modulo limit, count direction, wrap/saturate mode, synchronous load, count enable, a terminal-count flag and a wrap pulse.
- Used as the general timing/sequencing counter for FSM and datapath control.

Parameters:
- WIDTH, 4: counter width in bits; minimum 1.
- STEP, 1: increment/decrement amount per enabled cycle; range 1 to 2^WIDTH-1.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; when 0, count holds.
- load  input  1  synchronous load strobe.
- load_value  input  WIDTH  value to load.
- limit  input  WIDTH  inclusive upper bound of the count range [0, limit].
- down  input  1  0 = count up, 1 = count down.
- saturate  input  1  0 = wrap at bounds, 1 = hold at bounds.
- count  output  WIDTH  registered counter value.
- tc  output  1  combinational terminal-count flag.
- wrapped  output  1  registered one-cycle pulse, high the cycle after a wrap occurred.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). The polarity and synchronicity are fixed.
- Reset: on a rising edge with reset=1, count <= 0 and wrapped <= 0. Reset overrides all other inputs and takes effect mid-operation with no partial update.
- Priority per edge: reset > load > enable > hold.
- Load: count <= min(load_value, limit); wrapped <= 0. The load takes one cycle and is visible on count the next cycle. load has priority over enable.
- Hold (enable=0, load=0): count unchanged; wrapped <= 0.
- Arithmetic: evaluate count+STEP and count-STEP in WIDTH+1 bits. Never rely on natural modulo-2^WIDTH overflow.
- Up (enable=1, down=0):
  - If count+STEP <= limit: count <= count+STEP; wrapped <= 0.
  - Else, wrap mode (saturate=0): count <= 0; wrapped <= 1.
  - Else, saturate mode (saturate=1): count <= limit; wrapped <= 0.
  - Wrap always goes to 0. It is not a remainder carry; residual step is discarded.
- Down (enable=1, down=1):
  - If count > limit, for example after limit was lowered: count <= limit; wrapped <= 0. The count is clamped, not treated as a wrap.
  - Else if count >= STEP: count <= count-STEP; wrapped <= 0.
  - Else, wrap mode: count <= limit; wrapped <= 1.
  - Else, saturate mode: count <= 0; wrapped <= 0.
- Up with count > limit: count+STEP > limit, so the up rules apply (wrap to 0 or saturate to limit).
- tc:
  - down=0: tc = (count == limit).
  - down=1: tc = (count == 0).
  - tc is purely combinational from the current count, limit and down. It does not depend on enable.
- limit = 0:
  - Counter stays at 0.
  - Up-wrap: wrapped pulses on every enabled cycle.
  - Down-wrap: wrapped also pulses on every enabled cycle, since 0 < STEP.
  - Saturate: wrapped stays 0.
  - tc = 1 in both directions.
- Direction or mode change takes effect on the same edge it is sampled. No pipeline; latency is 1 cycle from input to count.
- wrapped is high for exactly one cycle per wrap event. On back-to-back wraps it stays high continuously.
- No X propagation: every output is defined from the first edge with reset=1.

Test Plan (WIDTH=4, STEP=1 unless noted):
- Reset and limit 15: hold reset=1 for 2 edges, then enable=1, limit=15, up, wrap mode.
  - count 0,1,...,15,0; tc=1 at 15.
  - wrapped=1 only in the cycle count returns to 0.
- Modulo 9: limit=9, enable=1 → count cycles 0..9,0, with a wrapped pulse each time 0 follows 9.
  - Set saturate=1 → count sticks at 9, wrapped=0.
- Down with STEP=3: limit=10, load_value=7, load=1, then down=1, enable=1.
  - count 7,4,1,10 (wrapped=1), 7,...
  - With saturate=1, from 1 → 0, then holds 0 with tc=1.
- Load clamp and priority:
  - limit=5, load_value=12, load=1 and enable=1 on the same edge → count=5.
  - Next edge with enable=1, up, wrap → count=0, wrapped=1.
- Limit lowered below count: count=8, limit changes to 3.
  - Up, wrap → next count=0, wrapped=1.
  - Repeat from count=8, down → next count=3, wrapped=0.
- Reset mid-count: count=6, enable=1, assert reset for 1 edge → count=0, wrapped=0.
  - Counting resumes 1,2,... after reset is released.
